// File: rtl/seq_mult_add.sv
// Iterative shift-and-add multiply-accumulate: Result = Multiplicand * Multiplier + Addend.
// One multiplier bit is consumed per clock; this is the inverse operation of the restoring divider.
module seq_mult_add #(
   parameter int N = 4
) (
   input  logic           Clock,
   input  logic           Resetn,
   input  logic           Go,
   input  logic [N-1:0]   Multiplicand,
   input  logic [N-1:0]   Multiplier,
   input  logic [N-1:0]   Addend,
   output logic [2*N-1:0] Result,
   output logic           Busy,
   output logic           Done
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     m_q, m_d;
   logic [N:0]       a_q, a_d;
   logic [N-1:0]     q_q, q_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2*N-1:0]   res_q, res_d;

   logic [N:0]       sum;
   logic [2*N:0]     shifted;

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q <= IDLE;
         m_q     <= '0;
         a_q     <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         a_q     <= a_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end

   // The carry bit in A absorbs the add, so the shift never loses information.
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      a_d     = a_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      sum     = a_q + (q_q[0] ? {1'b0, m_q} : '0);
      shifted = {sum, q_q} >> 1;
      case (state_q)
         IDLE: begin
            if (Go) begin
               m_d     = Multiplicand;
               a_d     = {1'b0, Addend};
               q_d     = Multiplier;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d   = shifted[2*N:N];
            q_d   = shifted[N-1:0];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
               res_d   = shifted[2*N-1:0];
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign Result = res_q;
   assign Busy   = (state_q == RUN) || (state_q == DONE);
   assign Done   = (state_q == DONE);

endmodule

// File: tb/tb_seq_mult_add.sv
// Bench for seq_mult_add: a 4-bit and an 8-bit instance driven by directed and random operations.
module tb_seq_mult_add;

   logic        Clock = 1'b0;
   logic        Resetn;
   logic        go4, go8;
   logic [3:0]  m4, x4, a4;
   logic [7:0]  m8, x8, a8;
   logic [7:0]  res4;
   logic [15:0] res8;
   logic        busy4, done4, busy8, done8;

   int tests = 0;
   int fails = 0;

   always #5 Clock = ~Clock;

   seq_mult_add #(.N(4)) dut4 (
      .Clock(Clock), .Resetn(Resetn), .Go(go4),
      .Multiplicand(m4), .Multiplier(x4), .Addend(a4),
      .Result(res4), .Busy(busy4), .Done(done4)
   );

   seq_mult_add #(.N(8)) dut8 (
      .Clock(Clock), .Resetn(Resetn), .Go(go8),
      .Multiplicand(m8), .Multiplier(x8), .Addend(a8),
      .Result(res8), .Busy(busy8), .Done(done8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] cur_res(input bit w);
      return w ? {16'd0, res8} : {24'd0, res4};
   endfunction

   function automatic logic cur_busy(input bit w);
      return w ? busy8 : busy4;
   endfunction

   function automatic logic cur_done(input bit w);
      return w ? done8 : done4;
   endfunction

   task automatic drive(input bit w, input int unsigned m, input int unsigned x,
                        input int unsigned a, input logic go);
      if (w) begin
         m8 = m[7:0]; x8 = x[7:0]; a8 = a[7:0]; go8 = go;
      end else begin
         m4 = m[3:0]; x4 = x[3:0]; a4 = a[3:0]; go4 = go;
      end
   endtask

   // One full operation; the expected value comes straight from M*X+A.
   task automatic run_op(input bit w, input int unsigned m, input int unsigned x,
                         input int unsigned a, input bit disturb);
      int unsigned n;
      logic [31:0] exp;
      logic [31:0] prev;
      int          j;
      n    = w ? 8 : 4;
      exp  = m * x + a;
      prev = cur_res(w);
      @(negedge Clock);
      drive(w, m, x, a, 1'b1);
      @(negedge Clock);
      drive(w, m, x, a, 1'b0);
      chk("busy_after_go", {31'd0, cur_busy(w)}, 32'd1);
      chk("done_after_go", {31'd0, cur_done(w)}, 32'd0);
      j = 0;
      while (!cur_done(w) && j < 3 * int'(n)) begin
         if (j == 1) chk("result_held_in_run", cur_res(w), prev);
         if (disturb) drive(w, $urandom, $urandom, $urandom, 1'($urandom));
         @(negedge Clock);
         j++;
      end
      drive(w, 0, 0, 0, 1'b0);
      chk("latency", j, n);
      chk("result", cur_res(w), exp);
      chk("busy_in_done", {31'd0, cur_busy(w)}, 32'd1);
      @(negedge Clock);
      chk("done_one_cycle", {31'd0, cur_done(w)}, 32'd0);
      chk("busy_after_done", {31'd0, cur_busy(w)}, 32'd0);
      chk("result_held_after", cur_res(w), exp);
   endtask

   initial begin
      int pulses;
      int last_pulse;
      int j;

      Resetn = 1'b0;
      drive(1'b0, 0, 0, 0, 1'b1);
      drive(1'b1, 0, 0, 0, 1'b1);
      repeat (2) @(negedge Clock);
      chk("reset_res4", cur_res(1'b0), 32'd0);
      chk("reset_busy4", {31'd0, busy4}, 32'd0);
      chk("reset_done4", {31'd0, done4}, 32'd0);
      chk("reset_res8", cur_res(1'b1), 32'd0);
      chk("reset_busy8", {31'd0, busy8}, 32'd0);
      Resetn = 1'b1;
      go4 = 1'b0;
      go8 = 1'b0;
      repeat (2) @(negedge Clock);
      chk("idle_stays_4", {31'd0, busy4}, 32'd0);
      chk("idle_stays_8", {31'd0, busy8}, 32'd0);

      // Directed operations on the 4-bit unit
      run_op(1'b0, 3, 5, 2, 1'b0);
      run_op(1'b0, 4, 3, 1, 1'b0);
      run_op(1'b0, 15, 15, 15, 1'b0);
      run_op(1'b0, 0, 0, 9, 1'b0);
      run_op(1'b0, 3, 5, 2, 1'b1);

      // Go held high: a start every N+2 cycles
      @(negedge Clock);
      drive(1'b0, 2, 7, 0, 1'b1);
      pulses = 0;
      last_pulse = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge Clock);
         if (done4) begin
            chk("held_go_result", cur_res(1'b0), 32'd14);
            if (last_pulse < 0) chk("held_go_first", i, 5);
            else chk("held_go_period", i - last_pulse, 6);
            last_pulse = i;
            pulses++;
         end
      end
      chk("held_go_pulses", pulses, 3);
      go4 = 1'b0;
      j = 0;
      while (busy4 && j < 20) begin
         @(negedge Clock);
         j++;
      end
      chk("held_go_drains", {31'd0, busy4}, 32'd0);

      // Reset during the second iteration
      drive(1'b0, 15, 15, 0, 1'b1);
      @(negedge Clock);
      go4 = 1'b0;
      @(negedge Clock);
      Resetn = 1'b0;
      @(negedge Clock);
      Resetn = 1'b1;
      chk("midrst_busy", {31'd0, busy4}, 32'd0);
      chk("midrst_done", {31'd0, done4}, 32'd0);
      chk("midrst_result", cur_res(1'b0), 32'd0);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clock);
         if (done4) pulses++;
      end
      chk("midrst_no_done", pulses, 0);
      run_op(1'b0, 5, 6, 3, 1'b0);

      // Wide instance
      run_op(1'b1, 255, 255, 255, 1'b0);

      for (int k = 0; k < 6; k++)
         run_op(1'b0, $urandom_range(15), $urandom_range(15), $urandom_range(15), k[0]);
      for (int k = 0; k < 3; k++)
         run_op(1'b1, $urandom_range(255), $urandom_range(255), $urandom_range(255), k[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
